// File: rtl/button_event.sv
// -----------------------------------------------------------------------------
// button_event
//
// Turns the debounced button level into single-cycle event strobes:
// press, release, long-press and auto-repeat while held. Also keeps a
// wrapping 8-bit count of presses. All outputs are registered.
//
// Parameters:
//   LONG_PRESS_CYCLES : high samples (counting the press sample) before the
//                       long-press strobe. Must be >= 2.
//   REPEAT_CYCLES     : period of the repeat strobe once held; 0 disables it.
//   CNT_WIDTH         : hold/repeat counter width; must hold both counts.
//
// Ports:
//   clk               : system clock
//   rst_n             : synchronous active-low reset
//   data_debounced    : debounced button level, 1 = pressed
//   pressed           : 1 while the button is considered down
//   press_pulse       : one-cycle strobe on a new press
//   release_pulse     : one-cycle strobe on release
//   long_press_pulse  : one-cycle strobe when the hold reaches the long count
//   repeat_pulse      : one-cycle strobe every REPEAT_CYCLES while held
//   press_count       : number of presses, wraps 255 -> 0
// -----------------------------------------------------------------------------
module button_event #(
  parameter int unsigned LONG_PRESS_CYCLES = 50_000_000,
  parameter int unsigned REPEAT_CYCLES     = 10_000_000,
  parameter int unsigned CNT_WIDTH         = 26
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_debounced,
  output logic       pressed,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_press_pulse,
  output logic       repeat_pulse,
  output logic [7:0] press_count
);

  localparam logic [CNT_WIDTH-1:0] LONG_C = CNT_WIDTH'(LONG_PRESS_CYCLES);
  localparam logic [CNT_WIDTH-1:0] REP_C  = CNT_WIDTH'(REPEAT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] ONE_C  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] MAX_C  = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_HELD
  } state_e;

  state_e               state_q;
  logic [CNT_WIDTH-1:0] hcnt_q;
  logic [CNT_WIDTH-1:0] rcnt_q;
  logic [CNT_WIDTH-1:0] hcnt_d;
  logic [CNT_WIDTH-1:0] rcnt_d;
  logic [7:0]           press_count_q;
  logic [7:0]           press_count_d;
  logic                 pressed_q;
  logic                 press_pulse_q;
  logic                 release_pulse_q;
  logic                 long_press_pulse_q;
  logic                 repeat_pulse_q;

  // Hold counter saturates instead of wrapping during very long holds.
  assign hcnt_d        = (hcnt_q == MAX_C) ? hcnt_q : hcnt_q + ONE_C;
  assign rcnt_d        = rcnt_q + ONE_C;
  assign press_count_d = press_count_q + 8'd1;

  // The state itself remembers whether the button is down, so there is no
  // separate edge-detect register: a release and the following press are
  // distinct samples and can never be merged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q            <= ST_IDLE;
      hcnt_q             <= '0;
      rcnt_q             <= '0;
      press_count_q      <= 8'd0;
      pressed_q          <= 1'b0;
      press_pulse_q      <= 1'b0;
      release_pulse_q    <= 1'b0;
      long_press_pulse_q <= 1'b0;
      repeat_pulse_q     <= 1'b0;
    end else begin
      // Strobes are high for one cycle only unless re-asserted below.
      press_pulse_q      <= 1'b0;
      release_pulse_q    <= 1'b0;
      long_press_pulse_q <= 1'b0;
      repeat_pulse_q     <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (data_debounced) begin
            state_q       <= ST_PRESSED;
            pressed_q     <= 1'b1;
            press_pulse_q <= 1'b1;
            hcnt_q        <= ONE_C;
            press_count_q <= press_count_d;
          end
        end

        ST_PRESSED: begin
          if (!data_debounced) begin
            state_q         <= ST_IDLE;
            pressed_q       <= 1'b0;
            release_pulse_q <= 1'b1;
            hcnt_q          <= '0;
          end else begin
            hcnt_q <= hcnt_d;
            // hcnt counts the press sample as 1, so this fires on the
            // LONG_PRESS_CYCLES-th consecutive high sample.
            if (hcnt_d == LONG_C) begin
              state_q            <= ST_HELD;
              long_press_pulse_q <= 1'b1;
              rcnt_q             <= '0;
            end
          end
        end

        ST_HELD: begin
          if (!data_debounced) begin
            state_q         <= ST_IDLE;
            pressed_q       <= 1'b0;
            release_pulse_q <= 1'b1;
            hcnt_q          <= '0;
            rcnt_q          <= '0;
          end else begin
            hcnt_q <= hcnt_d;
            if (REPEAT_CYCLES != 0) begin
              if (rcnt_d == REP_C) begin
                repeat_pulse_q <= 1'b1;
                rcnt_q         <= '0;
              end else begin
                rcnt_q <= rcnt_d;
              end
            end
          end
        end

        default: begin
          state_q   <= ST_IDLE;
          pressed_q <= 1'b0;
          hcnt_q    <= '0;
          rcnt_q    <= '0;
        end
      endcase
    end
  end

  assign pressed          = pressed_q;
  assign press_pulse      = press_pulse_q;
  assign release_pulse    = release_pulse_q;
  assign long_press_pulse = long_press_pulse_q;
  assign repeat_pulse     = repeat_pulse_q;
  assign press_count      = press_count_q;

endmodule

// File: tb/tb_button_event.sv
// -----------------------------------------------------------------------------
// tb_button_event
//
// Directed test of button_event with LONG_PRESS_CYCLES=8, REPEAT_CYCLES=4 and
// a 20 ns clock. Each step drives reset/input on the falling edge, lets one
// rising edge sample them, and checks every output 1 ns later against
// hand-computed expected strobes.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_button_event;

  localparam int unsigned LONG_P = 8;
  localparam int unsigned REP_P  = 4;

  logic       clk;
  logic       rst_n;
  logic       data_debounced;
  logic       pressed;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_press_pulse;
  logic       repeat_pulse;
  logic [7:0] press_count;

  int         n_cmp;
  int         n_err;
  int         cyc;
  string      scen;
  logic [7:0] exp_cnt;

  button_event #(
    .LONG_PRESS_CYCLES(LONG_P),
    .REPEAT_CYCLES    (REP_P),
    .CNT_WIDTH        (26)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .data_debounced  (data_debounced),
    .pressed         (pressed),
    .press_pulse     (press_pulse),
    .release_pulse   (release_pulse),
    .long_press_pulse(long_press_pulse),
    .repeat_pulse    (repeat_pulse),
    .press_count     (press_count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s/%s cyc%0d: got %0d, expected %0d", scen, tag, cyc, obs, exp);
    end
  endtask

  // One clock: drive on the falling edge, check 1 ns after the rising edge.
  task automatic step(input logic r, input logic d,
                      input logic e_pp, input logic e_rp, input logic e_lp,
                      input logic e_rep, input logic e_pr);
    @(negedge clk);
    rst_n          = r;
    data_debounced = d;
    @(posedge clk);
    #1;
    if (!r)        exp_cnt = 8'd0;
    else if (e_pp) exp_cnt = exp_cnt + 8'd1;
    chk("press_pulse",   {31'd0, press_pulse},      {31'd0, e_pp});
    chk("release_pulse", {31'd0, release_pulse},    {31'd0, e_rp});
    chk("long_pulse",    {31'd0, long_press_pulse}, {31'd0, e_lp});
    chk("repeat_pulse",  {31'd0, repeat_pulse},     {31'd0, e_rep});
    chk("pressed",       {31'd0, pressed},          {31'd0, e_pr});
    chk("press_count",   {24'd0, press_count},      {24'd0, exp_cnt});
    cyc++;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    cyc            = 0;
    exp_cnt        = 8'd0;
    rst_n          = 1'b0;
    data_debounced = 1'b0;

    // Reset while the input is already high, then a press on release of reset.
    scen = "reset_high";
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("count_after_reset", {24'd0, press_count}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    $display("scenario %s done, press_count=%0d", scen, press_count);

    // Short press: 5 high samples.
    scen = "short";
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, i == 0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("count_short", {24'd0, press_count}, 32'd1);
    $display("scenario %s done, press_count=%0d", scen, press_count);

    // Long press: 20 high samples, long at 7, repeats at 11/15/19, release at 20.
    scen = "long";
    do_reset();
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'b1, i == 0, 1'b0, i == 7, (i == 11) || (i == 15) || (i == 19), 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("scenario %s done, press_count=%0d", scen, press_count);

    // Glitch, one-sample gap, another one-sample press: nothing merged.
    scen = "glitch";
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("count_glitch", {24'd0, press_count}, 32'd2);
    $display("scenario %s done, press_count=%0d", scen, press_count);

    // 256 short presses: counter wraps to 0, hold timing unaffected afterwards.
    scen = "wrap";
    do_reset();
    for (int i = 0; i < 256; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      if (i == 254) chk("count_255", {24'd0, press_count}, 32'd255);
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    chk("count_wrapped", {24'd0, press_count}, 32'd0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, i == 0, 1'b0, i == 7, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("count_after_wrap", {24'd0, press_count}, 32'd1);
    $display("scenario %s done, press_count=%0d", scen, press_count);

    // Reset at edge 10 of a long hold: no release, then a fresh press.
    scen = "reset_mid_hold";
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, i == 0, 1'b0, i == 7, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, i == 0, 1'b0, i == 7, 1'b0, 1'b1);
    chk("count_mid_hold", {24'd0, press_count}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    $display("scenario %s done, press_count=%0d", scen, press_count);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
